// File: rtl/debug_loader_if.sv
// ============================================================================
// debug_loader_if : UART command/byte input, IMEM write port and
//                   pipeline control bundle of the debug loader.
// Revision 1.0
// ============================================================================
`default_nettype none

interface debug_loader_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        halt_seen;
  logic        dump_busy;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        mips_enable;
  logic        step_pulse;
  logic        dump_req;
  logic        load_done;
  logic        err_overflow;

  modport slave (
    input  rx_done, rx_data, halt_seen, dump_busy,
    output imem_we, imem_addr, imem_wdata, mips_enable,
           step_pulse, dump_req, load_done, err_overflow
  );

  modport master (
    output rx_done, rx_data, halt_seen, dump_busy,
    input  imem_we, imem_addr, imem_wdata, mips_enable,
           step_pulse, dump_req, load_done, err_overflow
  );
endinterface

`default_nettype wire

// File: rtl/debug_loader.sv
// ============================================================================
// debug_loader : UART-driven program loader and run/step/dump controller.
// Optional inter-byte timeout: define DEBUG_LOADER_TIMEOUT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module debug_loader #(
  parameter int IMEM_DEPTH     = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst,
  debug_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WRITE     = 3'd2,
    S_RUN       = 3'd3,
    S_DUMP_REQ  = 3'd4,
    S_DUMP_WAIT = 3'd5
  } state_t;

  localparam logic [7:0]  C_CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  C_CMD_CONT  = 8'h43;
  localparam logic [7:0]  C_CMD_STEP  = 8'h53;
  localparam logic [7:0]  C_CMD_DUMP  = 8'h44;
  localparam logic [7:0]  C_CMD_HALT  = 8'h48;
  localparam logic [31:0] C_LAST_ADDR = 32'(IMEM_DEPTH - 1);

  state_t      r_state;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_run;
  logic        r_step;
  logic        r_dreq;
  logic        r_loaded;
  logic        r_ovf;
  logic        r_busy_seen;
  logic [31:0] w_word;
  logic        w_timeout;

  assign w_word = {r_shift, bus.rx_data};

`ifdef DEBUG_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_timer;

  assign w_timeout = (r_state == S_LOAD) && (r_byte_cnt != 2'd0) && !bus.rx_done &&
                     (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (r_state != S_LOAD || r_byte_cnt == 2'd0 || bus.rx_done || w_timeout) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= 2'd0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_run       <= 1'b0;
      r_step      <= 1'b0;
      r_dreq      <= 1'b0;
      r_loaded    <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy_seen <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_step <= 1'b0;
      r_dreq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.rx_done) begin
            case (bus.rx_data)
              C_CMD_LOAD: begin
                r_state    <= S_LOAD;
                r_addr     <= '0;
                r_byte_cnt <= 2'd0;
                r_loaded   <= 1'b0;
                r_ovf      <= 1'b0;
              end
              C_CMD_CONT: if (r_loaded) begin
                r_state <= S_RUN;
                r_run   <= 1'b1;
              end
              C_CMD_STEP: if (r_loaded) begin
                r_step  <= 1'b1;
                r_state <= S_DUMP_REQ;
              end
              C_CMD_DUMP: r_state <= S_DUMP_REQ;
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (bus.rx_done) begin
            r_shift <= w_word[23:0];
            if (r_byte_cnt == 2'd3) begin
              r_wdata    <= w_word;
              r_we       <= 1'b1;
              r_byte_cnt <= 2'd0;
              r_state    <= S_WRITE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end else if (w_timeout) begin
            r_byte_cnt <= 2'd0;
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + 32'd1;
          if (r_wdata == 32'd0) begin
            r_loaded <= 1'b1;
            r_state  <= S_IDLE;
          end else if (r_addr == C_LAST_ADDR) begin
            r_ovf    <= 1'b1;
            r_loaded <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            // A byte landing in the write cycle starts the next word.
            r_state <= S_LOAD;
            if (bus.rx_done) begin
              r_shift    <= {16'd0, bus.rx_data};
              r_byte_cnt <= 2'd1;
            end
          end
        end
        S_RUN: begin
          if (bus.halt_seen || (bus.rx_done && bus.rx_data == C_CMD_HALT)) begin
            r_run   <= 1'b0;
            r_state <= S_DUMP_REQ;
          end
        end
        S_DUMP_REQ: begin
          r_dreq      <= 1'b1;
          r_busy_seen <= 1'b0;
          r_state     <= S_DUMP_WAIT;
        end
        S_DUMP_WAIT: begin
          if (bus.dump_busy) begin
            r_busy_seen <= 1'b1;
          end else if (r_busy_seen) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_we      = r_we;
  assign bus.imem_addr    = r_addr;
  assign bus.imem_wdata   = r_wdata;
  assign bus.mips_enable  = r_run;
  assign bus.step_pulse   = r_step;
  assign bus.dump_req     = r_dreq;
  assign bus.load_done    = r_loaded;
  assign bus.err_overflow = r_ovf;

endmodule

`default_nettype wire

// File: doc/debug_loader.md
DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64: number of 32-bit instruction memory words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: inter-byte timeout, used only under DEBUG_LOADER_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low (rst=0 resets).
REQ-005 SHALL have port rx_done  in  1  one-cycle strobe from the UART receiver; rx_data is valid that cycle.
REQ-006 SHALL have port rx_data  in  8  received byte.
REQ-007 SHALL have port halt_seen  in  1  MIPS has retired a halt instruction (level).
REQ-008 SHALL have port dump_busy  in  1  the debug transmitter is sending a state dump.
REQ-009 SHALL have port imem_we  out  1  one-cycle instruction memory write enable.
REQ-010 SHALL have port imem_addr  out  32  word address of the write.
REQ-011 SHALL have port imem_wdata  out  32  write data.
REQ-012 SHALL have port mips_enable  out  1  pipeline run enable.
REQ-013 SHALL have port step_pulse  out  1  one-cycle single-clock enable for the pipeline.
REQ-014 SHALL have port dump_req  out  1  one-cycle request to start a transmitter dump.
REQ-015 SHALL have port load_done  out  1  a program has been loaded.
REQ-016 SHALL have port err_overflow  out  1  sticky flag: the load hit IMEM_DEPTH without a halt word.

Function
REQ-017 SHALL implement states IDLE, LOAD, WRITE, RUN, DUMP_REQ and DUMP_WAIT.
REQ-018 In IDLE, a command byte SHALL select the next state; bytes arriving in DUMP_REQ or DUMP_WAIT SHALL be ignored.
- 0x4C 'L': go to LOAD; imem_addr=0, byte count=0, load_done=0, err_overflow=0.
- 0x43 'C': go to RUN if load_done=1, else ignored.
- 0x53 'S': step_pulse=1 next cycle, then go to DUMP_REQ, if load_done=1.
- 0x44 'D': go to DUMP_REQ.
- Any other byte: ignored.
REQ-019 In LOAD, each rx_done byte SHALL be shifted in MSB first (first byte lands in bits [31:24]); on the 4th byte the word SHALL be latched and the block SHALL move to WRITE.
REQ-020 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=current address, imem_wdata=assembled word. imem_addr SHALL increment on the cycle after WRITE.
REQ-021 A byte received during the WRITE cycle SHALL be captured as byte 0 of the next word; no byte is lost.
REQ-022 Halt word 0x00000000 SHALL still be written; load_done SHALL then be set to 1 and the block SHALL return to IDLE.
REQ-023 A non-halt word written to address IMEM_DEPTH-1 SHALL set err_overflow=1 and load_done=1, and the block SHALL return to IDLE.
REQ-024 In RUN, mips_enable SHALL be 1; either halt_seen=1 or byte 0x48 'H' SHALL clear mips_enable on the next edge and move the block to DUMP_REQ.
REQ-025 DUMP_REQ SHALL drive dump_req=1 for one cycle and then go to DUMP_WAIT. DUMP_WAIT SHALL wait for dump_busy=1, then for dump_busy=0, then go to IDLE.
REQ-026 Outside RUN, mips_enable SHALL be 0. Outside WRITE, imem_we SHALL be 0. step_pulse and dump_req SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 Reset SHALL force state=IDLE, byte count=0, imem_addr=0, imem_wdata=0, and all 1-bit outputs to 0.
REQ-028 Reset asserted mid-LOAD SHALL discard the partial word and any pending write; load_done SHALL stay 0 until a complete new load.

Configuration
REQ-029 With macro DEBUG_LOADER_TIMEOUT_EN defined:
- In LOAD with byte count≠0, TIMEOUT_CYCLES cycles without rx_done SHALL clear the byte count.
- The block SHALL stay in LOAD, and imem_addr SHALL not change.
REQ-030 Without DEBUG_LOADER_TIMEOUT_EN, the timeout counter SHALL NOT exist and a partial word SHALL be held indefinitely.

Verification
REQ-031 Load test: send 'L', 20 01 00 05, 00 00 00 00 -> imem_we pulses at addr 0 with data 0x20010005, then at addr 1 with 0x00000000; load_done=1; state IDLE.
REQ-032 Overflow test: IMEM_DEPTH=4; send 'L' then 5 non-zero words -> 4 writes at addr 0..3; err_overflow=1; 5th word ignored as commands.
REQ-033 Run and halt test: after a load, send 'C' -> mips_enable=1; assert halt_seen -> mips_enable=0 next cycle, one dump_req pulse; dump_busy 1 for 10 cycles then 0 -> IDLE.
REQ-034 Step test: send 'S' with load_done=1 -> step_pulse for exactly 1 cycle, dump_req the following cycle; 'S' with load_done=0 -> no pulses.
REQ-035 Timeout test (macro defined, TIMEOUT_CYCLES=16): 'L', 2 bytes, 20 idle cycles, then 4 bytes AA BB CC DD -> single write of 0xAABBCCDD at addr 0.
REQ-036 Reset test: drive rst=0 after the 2nd byte of a word -> all outputs 0; a new 'L' plus 4 bytes writes at addr 0.
